engine_ctrl_fsm: RTL and testbench

Controller on the other side of the engine wrapper control channel. It accepts a job descriptor (per-port transfer lengths, watchdog limit) from the register-file/offload side. It drives the engine's start strobe and per-port max counts, then watches the engine's done/ready/idle flags and signals completion or abort with a one-cycle event. One instance sits in each accelerator's control block, between the register file and the engine wrapper.

---
 rtl/engine_ctrl_pkg.sv | 33 +++
 rtl/engine_ctrl_watchdog.sv | 28 ++
 rtl/engine_ctrl_fsm.sv | 150 +++++++++++++++
 tb/tb_engine_ctrl_fsm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/engine_ctrl_pkg.sv
// Shared types and default sizes for the engine control channel.
// Imported by the controller FSM, its watchdog and anything that builds job descriptors.
package engine_ctrl_pkg;

   localparam int unsigned DefaultNIn  = 2;
   localparam int unsigned DefaultNOut = 1;
   localparam int unsigned DefaultCntW = 16;
   localparam int unsigned DefaultToW  = 24;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StRun,
      StDrain,
      StDone,
      StAbort
   } ctrl_state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_ZERO_LEN = 2'd1,
      ERR_TIMEOUT  = 2'd2,
      ERR_SOFT_CLR = 2'd3
   } err_code_e;

   // Descriptor layout for the default port/width configuration.
   typedef struct packed {
      logic [DefaultNIn*DefaultCntW-1:0]  len_in;
      logic [DefaultNOut*DefaultCntW-1:0] len_out;
      logic [DefaultToW-1:0]              timeout;
   } job_desc_t;

endpackage

// File: rtl/engine_ctrl_watchdog.sv
// Saturating job cycle counter; hit_o flags the last cycle before the limit expires.
// A zero limit disables the hit output.
module engine_ctrl_watchdog #(
   parameter int unsigned TO_W = 24
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   input  logic            en_i,
   input  logic [TO_W-1:0] limit_i,
   output logic            hit_o
);

   logic [TO_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + TO_W'(1);
      end
   end

   assign hit_o = (limit_i != '0) && (cnt_q == (limit_i - TO_W'(1)));

endmodule

// File: rtl/engine_ctrl_fsm.sv
// Job controller for the engine wrapper: latches a descriptor, strobes start, then
// tracks done/ready/idle flags and reports completion or abort as one-cycle events.
module engine_ctrl_fsm
   import engine_ctrl_pkg::*;
#(
   parameter int unsigned N_IN  = DefaultNIn,
   parameter int unsigned N_OUT = DefaultNOut,
   parameter int unsigned CNT_W = DefaultCntW,
   parameter int unsigned TO_W  = DefaultToW
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   job_valid_i,
   output logic                   job_ready_o,
   input  logic [N_IN*CNT_W-1:0]  job_len_in_i,
   input  logic [N_OUT*CNT_W-1:0] job_len_out_i,
   input  logic [TO_W-1:0]        job_timeout_i,
   input  logic                   soft_clear_i,
   output logic                   start_o,
   output logic [N_IN*CNT_W-1:0]  max_in_o,
   output logic [N_OUT*CNT_W-1:0] max_out_o,
   output logic                   clear_o,
   input  logic                   done_i,
   input  logic                   ready_i,
   input  logic                   idle_i,
   output logic                   busy_o,
   output logic                   evt_done_o,
   output logic                   evt_err_o,
   output logic [1:0]             err_code_o
);

   ctrl_state_e            state_q;
   err_code_e              err_code_q;
   logic [N_IN*CNT_W-1:0]  max_in_q;
   logic [N_OUT*CNT_W-1:0] max_out_q;
   logic [TO_W-1:0]        timeout_q;
   logic                   guard_q;
   logic                   job_ready_q, start_q, clear_q, busy_q, evt_done_q, evt_err_q;

   logic zero_len, accept, wd_en, wd_hit, done_seen, ready_seen;

   always_comb begin
      zero_len = 1'b0;
      for (int k = 0; k < int'(N_IN); k++) begin
         if (job_len_in_i[k*CNT_W +: CNT_W] == '0) zero_len = 1'b1;
      end
      for (int k = 0; k < int'(N_OUT); k++) begin
         if (job_len_out_i[k*CNT_W +: CNT_W] == '0) zero_len = 1'b1;
      end
   end

   assign accept = (state_q == StIdle) && job_valid_i && !zero_len;
   assign wd_en  = (state_q == StStart) || (state_q == StRun) || (state_q == StDrain);

   // Engine flags are stale in START and the first RUN cycle; idle low in RUN means the
   // engine finished on its own.
   assign done_seen  = ((state_q == StRun) && !guard_q && (done_i || !idle_i)) ||
                       ((state_q == StDrain) && done_i);
   assign ready_seen = (state_q == StRun) && !guard_q && ready_i;

   engine_ctrl_watchdog #(
      .TO_W (TO_W)
   ) u_watchdog (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (accept),
      .en_i    (wd_en),
      .limit_i (timeout_q),
      .hit_o   (wd_hit)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         err_code_q  <= ERR_NONE;
         max_in_q    <= '0;
         max_out_q   <= '0;
         timeout_q   <= '0;
         guard_q     <= 1'b0;
         job_ready_q <= 1'b1;
         start_q     <= 1'b0;
         clear_q     <= 1'b0;
         busy_q      <= 1'b0;
         evt_done_q  <= 1'b0;
         evt_err_q   <= 1'b0;
      end else begin
         start_q    <= 1'b0;
         clear_q    <= 1'b0;
         evt_done_q <= 1'b0;
         evt_err_q  <= 1'b0;
         guard_q    <= (state_q == StStart);
         unique case (state_q)
            StIdle: begin
               if (job_valid_i) begin
                  if (zero_len) begin
                     err_code_q <= ERR_ZERO_LEN;
                     evt_err_q  <= 1'b1;
                  end else begin
                     max_in_q    <= job_len_in_i;
                     max_out_q   <= job_len_out_i;
                     timeout_q   <= job_timeout_i;
                     err_code_q  <= ERR_NONE;
                     state_q     <= StStart;
                     start_q     <= 1'b1;
                     busy_q      <= 1'b1;
                     job_ready_q <= 1'b0;
                  end
               end
            end
            StStart, StRun, StDrain: begin
               if (done_seen) begin
                  state_q    <= StDone;
                  evt_done_q <= 1'b1;
               end else if (soft_clear_i) begin
                  state_q    <= StAbort;
                  err_code_q <= ERR_SOFT_CLR;
                  clear_q    <= 1'b1;
                  evt_err_q  <= 1'b1;
               end else if (wd_hit) begin
                  state_q    <= StAbort;
                  err_code_q <= ERR_TIMEOUT;
                  clear_q    <= 1'b1;
                  evt_err_q  <= 1'b1;
               end else if (ready_seen) begin
                  state_q <= StDrain;
               end else if (state_q == StStart) begin
                  state_q <= StRun;
               end
            end
            StDone, StAbort: begin
               state_q     <= StIdle;
               busy_q      <= 1'b0;
               job_ready_q <= 1'b1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign job_ready_o = job_ready_q;
   assign start_o     = start_q;
   assign max_in_o    = max_in_q;
   assign max_out_o   = max_out_q;
   assign clear_o     = clear_q;
   assign busy_o      = busy_q;
   assign evt_done_o  = evt_done_q;
   assign evt_err_o   = evt_err_q;
   assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_engine_ctrl_fsm.sv
// Bench for engine_ctrl_fsm: directed scenarios plus random jobs, each checked cycle by
// cycle against an event-timeline model of the controller.
module tb_engine_ctrl_fsm;
   import engine_ctrl_pkg::*;

   localparam int MaxC = 64;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        job_valid = 1'b0;
   logic        job_ready;
   logic [31:0] job_len_in = '0;
   logic [15:0] job_len_out = '0;
   logic [23:0] job_timeout = '0;
   logic        soft_clear = 1'b0;
   logic        start, clear, busy, evt_done, evt_err;
   logic [31:0] max_in;
   logic [15:0] max_out;
   logic        done = 1'b0, ready = 1'b0, idle = 1'b1;
   logic [1:0]  err_code;

   int vectors = 0;
   int miscompares = 0;

   // Engine/software behaviour per cycle, indexed by cycles after the start_o cycle.
   bit done_v [MaxC];
   bit ready_v[MaxC];
   bit clr_v  [MaxC];
   bit idle_v [MaxC];

   engine_ctrl_fsm u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .job_valid_i  (job_valid),
      .job_ready_o  (job_ready),
      .job_len_in_i (job_len_in),
      .job_len_out_i(job_len_out),
      .job_timeout_i(job_timeout),
      .soft_clear_i (soft_clear),
      .start_o      (start),
      .max_in_o     (max_in),
      .max_out_o    (max_out),
      .clear_o      (clear),
      .done_i       (done),
      .ready_i      (ready),
      .idle_i       (idle),
      .busy_o       (busy),
      .evt_done_o   (evt_done),
      .evt_err_o    (evt_err),
      .err_code_o   (err_code)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".job_ready"}, 64'(job_ready), 64'd1);
      chk({tag, ".start"}, 64'(start), 64'd0);
      chk({tag, ".clear"}, 64'(clear), 64'd0);
      chk({tag, ".busy"}, 64'(busy), 64'd0);
      chk({tag, ".evt_done"}, 64'(evt_done), 64'd0);
      chk({tag, ".evt_err"}, 64'(evt_err), 64'd0);
      chk({tag, ".err_code"}, 64'(err_code), 64'd0);
      chk({tag, ".max_in"}, 64'(max_in), 64'd0);
      chk({tag, ".max_out"}, 64'(max_out), 64'd0);
   endtask

   task automatic clr_stim();
      for (int k = 0; k < MaxC; k++) begin
         done_v[k] = 1'b0;
         ready_v[k] = 1'b0;
         clr_v[k] = 1'b0;
         idle_v[k] = 1'b1;
      end
   endtask

   // Event cycle e (relative to start) and outcome: 0 done, 2 watchdog, 3 soft clear.
   // Flags count from the second cycle after start; idle low only counts before ready was seen.
   function automatic void predict(input int to, output int e, output int kind);
      bit drained = 1'b0;
      e = -1;
      kind = -1;
      for (int k = 0; k < MaxC - 1; k++) begin
         if (k >= 2 && (done_v[k] || (!drained && !idle_v[k]))) begin
            e = k + 1; kind = 0; return;
         end
         if (clr_v[k]) begin
            e = k + 1; kind = 3; return;
         end
         if (to != 0 && k == to - 1) begin
            e = k + 1; kind = 2; return;
         end
         if (k >= 2 && ready_v[k]) drained = 1'b1;
      end
   endfunction

   task automatic run_job(input string name, input logic [15:0] li0, input logic [15:0] li1,
                          input logic [15:0] lo0, input logic [23:0] to);
      int e, kind;
      job_desc_t d;
      predict(int'(to), e, kind);
      if (e < 0) begin
         chk({name, ".model_end"}, 64'd0, 64'd1);
         return;
      end
      d.len_in = {li1, li0};
      d.len_out = lo0;
      d.timeout = to;
      @(negedge clk);
      chk({name, ".accept_ready"}, 64'(job_ready), 64'd1);
      job_len_in = d.len_in;
      job_len_out = d.len_out;
      job_timeout = d.timeout;
      job_valid = 1'b1;
      for (int k = 0; k <= e; k++) begin
         string t;
         @(negedge clk);
         job_valid = 1'b0;
         t = $sformatf("%s.c%0d", name, k);
         chk({t, ".start"}, 64'(start), 64'(k == 0));
         chk({t, ".busy"}, 64'(busy), 64'd1);
         chk({t, ".job_ready"}, 64'(job_ready), 64'd0);
         chk({t, ".evt_done"}, 64'(evt_done), 64'(k == e && kind == 0));
         chk({t, ".evt_err"}, 64'(evt_err), 64'(k == e && kind != 0));
         chk({t, ".clear"}, 64'(clear), 64'(k == e && kind != 0));
         chk({t, ".err_code"}, 64'(err_code), (k == e) ? 64'(kind) : 64'd0);
         chk({t, ".max_in"}, 64'(max_in), 64'(d.len_in));
         chk({t, ".max_out"}, 64'(max_out), 64'(d.len_out));
         done = done_v[k];
         ready = ready_v[k];
         soft_clear = clr_v[k];
         idle = idle_v[k];
      end
      @(negedge clk);
      done = 1'b0; ready = 1'b0; soft_clear = 1'b0; idle = 1'b1;
      chk({name, ".post.busy"}, 64'(busy), 64'd0);
      chk({name, ".post.job_ready"}, 64'(job_ready), 64'd1);
      chk({name, ".post.evt_done"}, 64'(evt_done), 64'd0);
      chk({name, ".post.evt_err"}, 64'(evt_err), 64'd0);
      chk({name, ".post.clear"}, 64'(clear), 64'd0);
      chk({name, ".post.start"}, 64'(start), 64'd0);
      chk({name, ".post.err_code"}, 64'(err_code), 64'(kind));
   endtask

   initial begin
      // Reset
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst_ni = 1'b1;
      @(negedge clk);
      chk_reset_vals("after_reset");

      // Normal job with a drain phase
      clr_stim();
      ready_v[6] = 1'b1;
      done_v[9] = 1'b1;
      run_job("normal", 16'd4, 16'd4, 16'd2, 24'd0);

      // Zero-length job
      @(negedge clk);
      job_len_in = {16'd0, 16'd7};
      job_len_out = 16'd3;
      job_timeout = 24'd0;
      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
      chk("zero.evt_err", 64'(evt_err), 64'd1);
      chk("zero.err_code", 64'(err_code), 64'd1);
      chk("zero.start", 64'(start), 64'd0);
      chk("zero.busy", 64'(busy), 64'd0);
      chk("zero.job_ready", 64'(job_ready), 64'd1);
      chk("zero.clear", 64'(clear), 64'd0);
      @(negedge clk);
      chk("zero.evt_err_once", 64'(evt_err), 64'd0);
      chk("zero.err_hold", 64'(err_code), 64'd1);
      chk("zero.no_start", 64'(start), 64'd0);

      // Watchdog expiry, then stale done during the guard cycles
      clr_stim();
      run_job("watchdog", 16'd9, 16'd5, 16'd1, 24'd10);
      clr_stim();
      done_v[0] = 1'b1;
      done_v[1] = 1'b1;
      done_v[5] = 1'b1;
      run_job("stale_done", 16'd3, 16'd8, 16'd6, 24'd0);

      // done and soft clear together: done wins
      clr_stim();
      done_v[4] = 1'b1;
      clr_v[4] = 1'b1;
      run_job("done_vs_clr", 16'd2, 16'd2, 16'd2, 24'd30);

      // Soft clear alone, and engine self-termination via idle
      clr_stim();
      clr_v[3] = 1'b1;
      run_job("soft_clear", 16'd1, 16'd1, 16'd1, 24'd0);
      clr_stim();
      idle_v[3] = 1'b0;
      run_job("idle_low", 16'd5, 16'd6, 16'd7, 24'd0);

      // Reset in the middle of RUN
      @(negedge clk);
      job_len_in = {16'd11, 16'd12};
      job_len_out = 16'd13;
      job_timeout = 24'd0;
      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
      chk("midrst.start", 64'(start), 64'd1);
      repeat (2) @(negedge clk);
      rst_ni = 1'b0;
      done = 1'b1;
      @(negedge clk);
      rst_ni = 1'b1;
      done = 1'b0;
      chk_reset_vals("midrst.c0");
      @(negedge clk);
      chk_reset_vals("midrst.c1");
      clr_stim();
      done_v[3] = 1'b1;
      run_job("after_midrst", 16'd4, 16'd4, 16'd2, 24'd0);

      // Random jobs
      for (int j = 0; j < 20; j++) begin
         logic [23:0] to;
         clr_stim();
         for (int k = 0; k < MaxC; k++) begin
            done_v[k] = ($urandom_range(11, 0) == 0);
            ready_v[k] = ($urandom_range(5, 0) == 0);
            clr_v[k] = ($urandom_range(39, 0) == 0);
            idle_v[k] = ($urandom_range(29, 0) != 0);
         end
         done_v[40] = 1'b1;
         to = ($urandom_range(2, 0) == 0) ? 24'd0 : 24'($urandom_range(30, 1));
         run_job($sformatf("rand%0d", j), 16'($urandom_range(65535, 1)),
                 16'($urandom_range(65535, 1)), 16'($urandom_range(65535, 1)), to);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
